// File: rtl/adder_arb.sv
// Round-robin arbiter sharing one fixed-latency pipelined 8-bit adder among NREQ requesters,
// with tag-tracked result return and a drain/halt quiesce FSM. Optional: ADDER_ARB_CNT_EN.
module adder_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef ADDER_ARB_CNT_EN
  input  logic                 cnt_clr,
  output logic [16*NREQ-1:0]   grant_cnt,
`endif
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_cin,
  output logic                 add_vld,
  input  logic [7:0]           add_sum,
  input  logic                 add_cout,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [7:0]           rsp_sum,
  output logic                 rsp_cout,
  input  logic                 drain_req,
  output logic                 idle
);

  localparam int unsigned TW    = $clog2(NREQ);
  localparam int unsigned CW    = $clog2(LAT + 2) + 1;
  // The sum is only valid after edge E1+LAT, so the tag needs one stage beyond LAT.
  localparam int unsigned DEPTH = LAT + 1;

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   ptr_q;
  logic [TW-1:0]   gnt_idx;
  logic [TW-1:0]   cand;
  logic            gnt_found;
  logic            gnt_en;
  logic            xfer;

  logic [7:0]      add_a_q, add_b_q;
  logic            add_cin_q, add_vld_q;
  logic [TW-1:0]   tag_q;

  logic            pipe_vld_q [DEPTH];
  logic [TW-1:0]   pipe_tag_q [DEPTH];
  logic            rsp_evt;
  logic [NREQ-1:0] rsp_onehot;

  logic [NREQ-1:0] rsp_valid_q;
  logic [7:0]      rsp_sum_q;
  logic            rsp_cout_q;
  logic [CW-1:0]   inflight_q;

  assign gnt_en = (state_q == StRun) && !drain_req;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = TW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    req_ready = '0;
    if (gnt_en && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign xfer = gnt_en && gnt_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= TW'(NREQ - 1);
      add_a_q   <= 8'h00;
      add_b_q   <= 8'h00;
      add_cin_q <= 1'b0;
      add_vld_q <= 1'b0;
      tag_q     <= '0;
    end else begin
      add_vld_q <= xfer;
      if (xfer) begin
        ptr_q     <= gnt_idx;
        tag_q     <= gnt_idx;
        add_a_q   <= req_a[{gnt_idx, 3'b000} +: 8];
        add_b_q   <= req_b[{gnt_idx, 3'b000} +: 8];
        add_cin_q <= req_cin[gnt_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_tag_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= add_vld_q;
      pipe_tag_q[0] <= tag_q;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  assign rsp_evt = pipe_vld_q[DEPTH-1];

  always_comb begin
    rsp_onehot = '0;
    rsp_onehot[pipe_tag_q[DEPTH-1]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_sum_q   <= 8'h00;
      rsp_cout_q  <= 1'b0;
    end else if (rsp_evt) begin
      rsp_valid_q <= rsp_onehot;
      rsp_sum_q   <= add_sum;
      rsp_cout_q  <= add_cout;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      unique case ({xfer, rsp_evt})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (drain_req) state_d = StDrain;
      StDrain: if (inflight_q == '0 && !add_vld_q) state_d = StHalt;
      StHalt:  if (!drain_req) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StRun;
    else        state_q <= state_d;
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign add_vld   = add_vld_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign idle      = (state_q == StHalt);

`ifdef ADDER_ARB_CNT_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             cnt_q <= 16'h0000;
      else if (cnt_clr)                       cnt_q <= 16'h0000;
      else if (xfer && gnt_idx == TW'(g))     cnt_q <= cnt_q + 16'h0001;
    end
    assign grant_cnt[16*g +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_adder_arb.sv
// Scoreboard bench for adder_arb: directed vectors push expected results, a negedge monitor
// pops and compares them against rsp_* including arrival cycle.
module tb_adder_arb;

  localparam int unsigned LAT = 5;

  typedef struct {
    logic [3:0] onehot;
    logic [7:0] sum;
    logic       cout;
    int         due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_cin;
  logic [7:0]  add_a, add_b;
  logic        add_cin, add_vld;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic        drain_req;
  logic        idle;
`ifdef ADDER_ARB_CNT_EN
  logic        cnt_clr;
  logic [63:0] grant_cnt;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [8:0] apipe [0:LAT];

  adder_arb #(.NREQ(4), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ADDER_ARB_CNT_EN
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_vld   (add_vld),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .drain_req (drain_req),
    .idle      (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: samples at E1, result presented after edge E1+LAT.
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
    for (int i = 1; i <= LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_sum  = apipe[LAT][7:0];
  assign add_cout = apipe[LAT][8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [3:0] oh, input logic [7:0] s, input logic c);
    exp_t e;
    e.onehot = oh;
    e.sum    = s;
    e.cout   = c;
    e.due    = cyc + 1 + LAT + 2;
    sb.push_back(e);
  endtask

  // Called in the negedge phase; the transfer edge is the next posedge.
  task automatic issue(input logic [3:0] vld, input logic [3:0] exp_gnt,
                       input logic [7:0] exp_sum, input logic exp_cout);
    req_valid = vld;
    #1;
    chk("grant", {28'h0, req_ready}, {28'h0, exp_gnt});
    if (exp_gnt != 4'b0000) push_exp(exp_gnt, exp_sum, exp_cout);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {28'h0, rsp_valid}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_valid", {28'h0, rsp_valid}, {28'h0, mon_e.onehot});
          chk("rsp_sum", {24'h0, rsp_sum}, {24'h0, mon_e.sum});
          chk("rsp_cout", {31'h0, rsp_cout}, {31'h0, mon_e.cout});
          chk("rsp_cycle", cyc, mon_e.due);
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        chk("missing_rsp", cyc, 32'(sb[0].due) - 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_add_a", {24'h0, add_a}, 32'h0);
    chk("rst_add_b", {24'h0, add_b}, 32'h0);
    chk("rst_add_cin", {31'h0, add_cin}, 32'h0);
    chk("rst_add_vld", {31'h0, add_vld}, 32'h0);
    chk("rst_rsp_valid", {28'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_sum", {24'h0, rsp_sum}, 32'h0);
    chk("rst_rsp_cout", {31'h0, rsp_cout}, 32'h0);
    chk("rst_idle", {31'h0, idle}, 32'h0);
  endtask

  initial begin
    int last_rsp;
    int idle_at;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_a     = 32'h0;
    req_b     = 32'h0;
    req_cin   = 4'b0000;
    drain_req = 1'b0;
`ifdef ADDER_ARB_CNT_EN
    cnt_clr   = 1'b0;
`endif
    wait_cyc(3);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All four valid from reset: 0,1,2,3,0; FF+FF+1 = 1FF.
    req_a = {4{8'hFF}};
    req_b = {4{8'hFF}};
    req_cin = 4'hF;
    issue(4'hF, 4'b0001, 8'hFF, 1'b1);
    issue(4'hF, 4'b0010, 8'hFF, 1'b1);
    issue(4'hF, 4'b0100, 8'hFF, 1'b1);
    issue(4'hF, 4'b1000, 8'hFF, 1'b1);
    issue(4'hF, 4'b0001, 8'hFF, 1'b1);
    req_valid = 4'b0000;
    wait_cyc(LAT + 3);

    // Single op from requester 1: 7F+01+1 = 081.
    req_a = {8'h00, 8'h00, 8'h7F, 8'h00};
    req_b = {8'h00, 8'h00, 8'h01, 8'h00};
    req_cin = 4'b0010;
    issue(4'b0010, 4'b0010, 8'h81, 1'b0);
    chk("issue_vld", {31'h0, add_vld}, 32'h1);
    chk("issue_a", {24'h0, add_a}, 32'h7F);
    chk("issue_b", {24'h0, add_b}, 32'h01);
    chk("issue_cin", {31'h0, add_cin}, 32'h1);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("idle_vld", {31'h0, add_vld}, 32'h0);
    chk("hold_a", {24'h0, add_a}, 32'h7F);
    wait_cyc(LAT + 3);

    // Requesters 0 and 2 alternate once ptr is 0: 10+20 = 30, C0+50+1 = 111.
    req_a = {8'h00, 8'hC0, 8'h00, 8'h10};
    req_b = {8'h00, 8'h50, 8'h00, 8'h20};
    req_cin = 4'b0100;
    issue(4'b0001, 4'b0001, 8'h30, 1'b0);
    issue(4'b0101, 4'b0100, 8'h11, 1'b1);
    issue(4'b0101, 4'b0001, 8'h30, 1'b0);
    issue(4'b0101, 4'b0100, 8'h11, 1'b1);
    req_valid = 4'b0000;
    wait_cyc(LAT + 3);

    // Drain with three in flight; ptr is 2 so grants go 3,0,1.
    req_a = {8'h04, 8'h03, 8'h02, 8'h01};
    req_b = {8'h40, 8'h30, 8'h20, 8'h10};
    req_cin = 4'b0000;
    issue(4'hF, 4'b1000, 8'h44, 1'b0);
    issue(4'hF, 4'b0001, 8'h11, 1'b0);
    issue(4'hF, 4'b0010, 8'h22, 1'b0);
    drain_req = 1'b1;
    #1;
    chk("drain_block", {28'h0, req_ready}, 32'h0);
    last_rsp = -100;
    idle_at  = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid != 4'b0000) last_rsp = cyc;
      if (idle && idle_at < 0) idle_at = cyc;
    end
    chk("idle_delay", 32'(idle_at - last_rsp), 32'h1);
    chk("halt_idle", {31'h0, idle}, 32'h1);
    chk("halt_ready", {28'h0, req_ready}, 32'h0);
    drain_req = 1'b0;
    #1;
    chk("resume_ready0", {28'h0, req_ready}, 32'h0);
    @(negedge clk);
    chk("resume_idle", {31'h0, idle}, 32'h0);
    issue(4'hF, 4'b0100, 8'h33, 1'b0);
    req_valid = 4'b0000;
    wait_cyc(LAT + 3);

    // Reset two cycles after issue discards the op and restores ptr.
    issue(4'hF, 4'b1000, 8'h44, 1'b0);
    req_valid = 4'b0000;
    wait_cyc(2);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_vals();
    chk("rst_ready", {28'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_rsp", {28'h0, rsp_valid}, 32'h0);
    end
    issue(4'b0101, 4'b0001, 8'h11, 1'b0);
    req_valid = 4'b0000;
    wait_cyc(LAT + 3);

`ifdef ADDER_ARB_CNT_EN
    // Clear wins over a coincident grant, then 70000 grants wrap to 0x1170.
    cnt_clr = 1'b1;
    issue(4'b1000, 4'b1000, 8'h44, 1'b0);
    cnt_clr = 1'b0;
    chk("cnt_clr", {16'h0, grant_cnt[63:48]}, 32'h0);
    req_valid = 4'b1000;
    for (int i = 0; i < 70000; i++) begin
      push_exp(4'b1000, 8'h44, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 4'b0000;
    chk("cnt_wrap", {16'h0, grant_cnt[63:48]}, 32'h1170);
    wait_cyc(LAT + 3);
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
